// File: rtl/mips_pkg.sv
// Shared MIPS core constants: register-file defaults, the hard-wired zero register
// and the ALU control codes used by the surrounding datapath.
package mips_pkg;

    localparam int REG_ZERO       = 0;
    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_NREGS  = 32;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12
    } alu_ctrl_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Register-file bundle: read ports, ALU writeback, load return, load claim and
// scoreboard status. master drives requests; slave is the register file.
interface regfile_sb_if
    import mips_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NREGS  = DEFAULT_NREGS,
    parameter int NRD    = 2,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) ();

    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  ld_en;
    logic [AW-1:0]         ld_addr;
    logic [DATA_W-1:0]     ld_data;
    logic                  claim_en;
    logic [AW-1:0]         claim_addr;
    logic [CW-1:0]         busy_cnt;
    logic                  sb_err;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, ld_en, ld_addr, ld_data,
               claim_en, claim_addr,
        input  rd_data, rd_busy, busy_cnt, sb_err
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, ld_en, ld_addr, ld_data,
               claim_en, claim_addr,
        output rd_data, rd_busy, busy_cnt, sb_err
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: busy vector, pending count and sticky protocol error.
// Latency: busy/busy_cnt/sb_err update one cycle after the claim/load/write.
// Backpressure: none; errors are only flagged, the caller stalls on busy.
module regfile_scoreboard
    import mips_pkg::*;
#(
    parameter int NREGS = DEFAULT_NREGS,
    localparam int AW   = $clog2(NREGS),
    localparam int CW   = $clog2(NREGS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic             claim_en,
    input  logic [AW-1:0]    claim_addr,
    output logic [NREGS-1:0] busy,
    output logic [CW-1:0]    busy_cnt,
    output logic             sb_err
);

    logic             wr_hit, ld_hit, claim_hit;
    logic             clr, set_new, err;
    logic [NREGS-1:0] busy_nxt;
    logic [CW-1:0]    cnt_nxt;

    always_comb begin
        wr_hit    = wr_en    && (wr_addr    != AW'(REG_ZERO));
        ld_hit    = ld_en    && (ld_addr    != AW'(REG_ZERO));
        claim_hit = claim_en && (claim_addr != AW'(REG_ZERO));
        clr       = ld_hit && busy[ld_addr];
        // A claim re-arming a register its own load is clearing counts as a fresh set.
        set_new   = claim_hit && (!busy[claim_addr] || (clr && (ld_addr == claim_addr)));
        busy_nxt  = busy;
        if (clr)       busy_nxt[ld_addr]    = 1'b0;
        if (claim_hit) busy_nxt[claim_addr] = 1'b1;
        err = (claim_hit && busy[claim_addr] && !(clr && (ld_addr == claim_addr)))
            || (ld_hit && !busy[ld_addr])
            || (wr_hit && busy[wr_addr] && !(clr && (ld_addr == wr_addr)));
        cnt_nxt = busy_cnt + CW'(set_new) - CW'(clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
            sb_err   <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
            if (err) sb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with pending-load scoreboard.
// Latency: reads combinational with same-cycle write bypass; stores visible next cycle.
// Backpressure: none; rd_busy tells the control FSM to stall on outstanding loads.
module regfile_sb
    import mips_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NREGS  = DEFAULT_NREGS,
    parameter int NRD    = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic  clk,
    input  logic  rst,
    regfile_sb_if.slave bus
);

    logic [DATA_W-1:0] mem [NREGS];
    logic [NREGS-1:0]  busy;
    logic              wr_hit, ld_hit;

    assign wr_hit = bus.wr_en && (bus.wr_addr != AW'(REG_ZERO));
    assign ld_hit = bus.ld_en && (bus.ld_addr != AW'(REG_ZERO));

    // Load return is written last so it wins a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) mem[r] <= '0;
        end else begin
            if (wr_hit) mem[bus.wr_addr] <= bus.wr_data;
            if (ld_hit) mem[bus.ld_addr] <= bus.ld_data;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          ld_match, wr_match;

        assign ra       = bus.rd_addr[i*AW +: AW];
        assign ld_match = bus.ld_en && (bus.ld_addr == ra);
        assign wr_match = bus.wr_en && (bus.wr_addr == ra);

        assign bus.rd_data[i*DATA_W +: DATA_W] =
            (ra == AW'(REG_ZERO)) ? '0          :
            ld_match              ? bus.ld_data :
            wr_match              ? bus.wr_data :
                                    mem[ra];
        assign bus.rd_busy[i] = busy[ra] & ~ld_match;
    end

    regfile_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (bus.wr_en),
        .wr_addr    (bus.wr_addr),
        .ld_en      (bus.ld_en),
        .ld_addr    (bus.ld_addr),
        .claim_en   (bus.claim_en),
        .claim_addr (bus.claim_addr),
        .busy       (busy),
        .busy_cnt   (bus.busy_cnt),
        .sb_err     (bus.sb_err)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: stimulus pushes expected values tagged with the
// cycle they become due; a negedge monitor pops and compares them.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int NP = 2;

    localparam int K_DATA = 0;
    localparam int K_BUSY = 1;
    localparam int K_CNT  = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        string       nm;
        int          kind;
        int          port;
        logic [31:0] val;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    regfile_sb_if #(.DATA_W(DW), .NREGS(NR), .NRD(NP)) bus ();

    regfile_sb #(.DATA_W(DW), .NREGS(NR), .NRD(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int kind, input int port);
        case (kind)
            K_DATA:  return bus.rd_data[port*DW +: DW];
            K_BUSY:  return {31'd0, bus.rd_busy[port]};
            K_CNT:   return 32'(bus.busy_cnt);
            default: return {31'd0, bus.sb_err};
        endcase
    endfunction

    always @(negedge clk) begin
        int i;
        logic [31:0] a;
        i = 0;
        while (i < q.size()) begin
            if (q[i].due <= cyc) begin
                a = actual(q[i].kind, q[i].port);
                checks++;
                if (a !== q[i].val) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                             q[i].nm, a, q[i].val, cyc);
                end
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic expect_v(input string nm, input int kind, input int port,
                            input logic [31:0] v, input int lag);
        exp_t e;
        e.nm = nm; e.kind = kind; e.port = port; e.val = v; e.due = cyc + lag;
        q.push_back(e);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0; bus.ld_en = 1'b0; bus.claim_en = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        bus.rd_addr = {5'(a1), 5'(a0)};
    endtask

    task automatic do_wr(input int a, input logic [31:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = 5'(a); bus.wr_data = d;
    endtask

    task automatic do_ld(input int a, input logic [31:0] d);
        bus.ld_en = 1'b1; bus.ld_addr = 5'(a); bus.ld_data = d;
    endtask

    task automatic do_claim(input int a);
        bus.claim_en = 1'b1; bus.claim_addr = 5'(a);
    endtask

    initial begin
        bus.rd_addr = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        bus.claim_en = 1'b0; bus.claim_addr = '0;
        repeat (2) next_cyc();

        // Reset state
        next_cyc(); rst = 1'b0; set_rd(5, 0);
        expect_v("rst_rd0", K_DATA, 0, 32'h0, 0);
        expect_v("rst_rd1", K_DATA, 1, 32'h0, 0);
        expect_v("rst_cnt", K_CNT, 0, 32'd0, 0);
        expect_v("rst_err", K_ERR, 0, 32'd0, 0);

        // Write bypass, then stored value
        next_cyc(); do_wr(3, 32'hDEADBEEF); set_rd(3, 0);
        expect_v("wr_bypass", K_DATA, 0, 32'hDEADBEEF, 0);
        next_cyc();
        expect_v("wr_stored", K_DATA, 0, 32'hDEADBEEF, 0);

        // Claim, stall, load return
        next_cyc(); do_claim(7);
        expect_v("claim_cnt_lag", K_CNT, 0, 32'd0, 0);
        next_cyc(); set_rd(7, 0);
        expect_v("claim_busy", K_BUSY, 0, 32'd1, 0);
        expect_v("claim_cnt", K_CNT, 0, 32'd1, 0);
        next_cyc(); do_ld(7, 32'h55);
        expect_v("ld_unstall", K_BUSY, 0, 32'd0, 0);
        expect_v("ld_bypass", K_DATA, 0, 32'h55, 0);
        expect_v("ld_cnt_now", K_CNT, 0, 32'd1, 0);
        expect_v("ld_cnt_next", K_CNT, 0, 32'd0, 1);
        expect_v("ld_err", K_ERR, 0, 32'd0, 1);
        next_cyc();
        expect_v("ld_stored", K_DATA, 0, 32'h55, 0);

        // Write/load collision on a pending register
        next_cyc(); do_claim(4);
        next_cyc(); do_wr(4, 32'd1); do_ld(4, 32'd2); set_rd(4, 4);
        expect_v("coll_bypass", K_DATA, 0, 32'd2, 0);
        expect_v("coll_err", K_ERR, 0, 32'd0, 1);
        expect_v("coll_cnt", K_CNT, 0, 32'd0, 1);
        next_cyc();
        expect_v("coll_stored", K_DATA, 1, 32'd2, 0);

        // Same-cycle load and claim to one register
        next_cyc(); do_claim(12);
        next_cyc(); do_ld(12, 32'h77); do_claim(12); set_rd(12, 0);
        expect_v("ldcl_busy", K_BUSY, 0, 32'd0, 0);
        expect_v("ldcl_data", K_DATA, 0, 32'h77, 0);
        expect_v("ldcl_cnt", K_CNT, 0, 32'd1, 1);
        expect_v("ldcl_err", K_ERR, 0, 32'd0, 1);
        next_cyc();
        expect_v("ldcl_rebusy", K_BUSY, 0, 32'd1, 0);
        next_cyc(); do_ld(12, 32'h78);
        expect_v("ldcl_drain", K_CNT, 0, 32'd0, 1);

        // Register zero
        next_cyc(); do_claim(0); do_wr(0, 32'hFFFF); set_rd(0, 0);
        expect_v("r0_bypass", K_DATA, 0, 32'h0, 0);
        expect_v("r0_busy", K_BUSY, 0, 32'd0, 0);
        expect_v("r0_cnt", K_CNT, 0, 32'd0, 1);
        expect_v("r0_err", K_ERR, 0, 32'd0, 1);
        next_cyc();
        expect_v("r0_stored", K_DATA, 1, 32'h0, 0);
        expect_v("r0_busy_next", K_BUSY, 1, 32'd0, 0);

        // Double claim error, sticky
        next_cyc(); do_claim(9);
        next_cyc(); do_claim(9);
        expect_v("dbl_err_pre", K_ERR, 0, 32'd0, 0);
        expect_v("dbl_err", K_ERR, 0, 32'd1, 1);
        expect_v("dbl_cnt", K_CNT, 0, 32'd1, 1);
        next_cyc();
        expect_v("dbl_err_sticky", K_ERR, 0, 32'd1, 1);

        // Asynchronous reset with three pending
        next_cyc(); do_claim(10);
        next_cyc(); do_claim(11);
        next_cyc(); set_rd(9, 11);
        expect_v("pend_cnt", K_CNT, 0, 32'd3, 0);
        expect_v("pend_busy0", K_BUSY, 0, 32'd1, 0);
        expect_v("pend_busy1", K_BUSY, 1, 32'd1, 0);
        next_cyc(); #1; rst = 1'b1;
        expect_v("arst_cnt", K_CNT, 0, 32'd0, 0);
        expect_v("arst_busy0", K_BUSY, 0, 32'd0, 0);
        expect_v("arst_busy1", K_BUSY, 1, 32'd0, 0);
        expect_v("arst_err", K_ERR, 0, 32'd0, 0);
        next_cyc(); set_rd(3, 0);
        expect_v("arst_data", K_DATA, 0, 32'h0, 0);

        // Load to a non-pending register
        next_cyc(); rst = 1'b0; do_ld(5, 32'd1);
        expect_v("ldnb_err_pre", K_ERR, 0, 32'd0, 0);
        expect_v("ldnb_err", K_ERR, 0, 32'd1, 1);
        expect_v("ldnb_cnt", K_CNT, 0, 32'd0, 1);

        for (int n = 0; n < 20 && q.size() > 0; n++) next_cyc();
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
